// File: rtl/muldiv_exec_unit.sv
// Iterative RV32M/RV64M multiply/divide execute unit: shift-add multiply and
// restoring divide, STEP_BITS bits retired per clock, registered writeback.
module muldiv_exec_unit #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1   // 1, 2 or 4, and must divide XLEN
) (
  input  logic            clock_i,
  input  logic            nreset_i,
  input  logic            du_bubble_i,
  input  logic            du_is_muldiv_i,
  input  logic [2:0]      du_func3_i,
  input  logic [4:0]      du_rdt_i,
  input  logic [XLEN-1:0] reg_file_rs0_i,
  input  logic [XLEN-1:0] reg_file_rs1_i,
  input  logic            mem_stall_i,
  input  logic            flush_i,
  output logic            du_stall_o,
  output logic            busy_o,
  output logic            xu_bubble_o,
  output logic [4:0]      rdt_addr_o,
  output logic [XLEN-1:0] rdt_data_o
);

  localparam int N  = XLEN / STEP_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          func3_q;
  logic [4:0]          rd_q;
  logic                neg_prod_q, neg_rem_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   p_q;

  logic                sign_a, sign_b, neg_a, neg_b, is_div_in;
  logic [XLEN-1:0]     mag_a, mag_b, fast_res;
  logic                div_zero, div_ovf, fast, acc, calc;

  // Handshake: an instruction transfers on an edge where du_bubble_i=0,
  // du_is_muldiv_i=1, flush_i=0 and the unit is ready (IDLE, or DONE with
  // mem_stall_i=0); du_stall_o=1 tells decode to hold. A result is valid
  // while xu_bubble_o=0 and is consumed on any edge with mem_stall_i=0.
  assign calc      = (state_q == CALC);
  assign is_div_in = du_func3_i[2];
  assign sign_a    = du_func3_i inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign sign_b    = du_func3_i inside {3'b001, 3'b100, 3'b110};
  assign neg_a     = sign_a & reg_file_rs0_i[XLEN-1];
  assign neg_b     = sign_b & reg_file_rs1_i[XLEN-1];
  assign mag_a     = neg_a ? -reg_file_rs0_i : reg_file_rs0_i;
  assign mag_b     = neg_b ? -reg_file_rs1_i : reg_file_rs1_i;
  assign div_zero  = is_div_in & (reg_file_rs1_i == '0);
  assign div_ovf   = is_div_in & !du_func3_i[0] & (reg_file_rs0_i == MIN_NEG)
                     & (reg_file_rs1_i == '1);
  assign fast      = div_zero | div_ovf;
  assign fast_res  = div_zero ? (du_func3_i[1] ? reg_file_rs0_i : '1)
                              : (du_func3_i[1] ? '0 : MIN_NEG);
  assign acc       = !du_bubble_i & du_is_muldiv_i & !flush_i &
                     ((state_q == IDLE) | ((state_q == DONE) & !mem_stall_i));
  assign du_stall_o = calc | ((state_q == DONE) & mem_stall_i);

  // The accept edge already retires the first step, so the step datapath
  // takes freshly decoded operands at accept and the registers in CALC.
  logic                step_div, ge;
  logic [XLEN-1:0]     step_opnd;
  logic [2*XLEN-1:0]   step_p, step_out;
  logic [XLEN:0]       rem_t;
  logic [XLEN+STEP_BITS-1:0] mul_sum;

  assign step_div  = calc ? func3_q[2] : is_div_in;
  assign step_opnd = calc ? opnd_q : (is_div_in ? mag_b : mag_a);
  assign step_p    = calc ? p_q : {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};

  always_comb begin
    step_out = step_p;
    rem_t    = '0;
    ge       = 1'b0;
    mul_sum  = '0;
    if (step_div) begin
      for (int i = 0; i < STEP_BITS; i++) begin
        rem_t = {step_out[2*XLEN-1:XLEN], step_out[XLEN-1]};
        ge    = (rem_t >= {1'b0, step_opnd});
        if (ge) rem_t = rem_t - {1'b0, step_opnd};
        step_out = {rem_t[XLEN-1:0], step_out[XLEN-2:0], ge};
      end
    end else begin
      mul_sum  = {{STEP_BITS{1'b0}}, step_p[2*XLEN-1:XLEN]} +
                 ({{STEP_BITS{1'b0}}, step_opnd} *
                  {{XLEN{1'b0}}, step_p[STEP_BITS-1:0]});
      step_out = {mul_sum, step_p[XLEN-1:STEP_BITS]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, result;

  always_comb begin
    prod = neg_prod_q ? -step_out : step_out;
    quot = neg_prod_q ? -step_out[XLEN-1:0] : step_out[XLEN-1:0];
    rem  = neg_rem_q ? -step_out[2*XLEN-1:XLEN] : step_out[2*XLEN-1:XLEN];
    case (func3_q)
      3'b000:                 result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quot;
      default:                result = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (acc) state_d = fast ? DONE : CALC;
        CALC:    if (cnt_q == CW'(1)) state_d = DONE;
        DONE:    if (!mem_stall_i) state_d = acc ? (fast ? DONE : CALC) : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!nreset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      func3_q     <= '0;
      rd_q        <= '0;
      neg_prod_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      opnd_q      <= '0;
      p_q         <= '0;
      xu_bubble_o <= 1'b1;
      busy_o      <= 1'b0;
      rdt_addr_o  <= '0;
      rdt_data_o  <= '0;
    end else begin
      state_q     <= state_d;
      xu_bubble_o <= (state_d != DONE);
      busy_o      <= (state_d != IDLE);
      if (acc) begin
        func3_q    <= du_func3_i;
        rd_q       <= du_rdt_i;
        neg_prod_q <= neg_a ^ neg_b;
        neg_rem_q  <= neg_a;
        opnd_q     <= is_div_in ? mag_b : mag_a;
        p_q        <= step_out;
        cnt_q      <= CW'(N - 1);
        if (fast) begin
          rdt_data_o <= fast_res;
          rdt_addr_o <= du_rdt_i;
        end
      end else if (calc) begin
        p_q   <= step_out;
        cnt_q <= cnt_q - 1'b1;
        if (state_d == DONE) begin
          rdt_data_o <= result;
          rdt_addr_o <= rd_q;
        end
      end
    end
  end

endmodule
